stopwatch_dp: RTL and testbench

- Stopwatch timekeeping datapath with run/stop/clear control.
- Sits directly upstream of the FND display controller and drives its msec/sec/min/hour inputs.
- Derives a 100 Hz count tick from the system clock, then counts centiseconds (0-99), seconds (0-59), minutes (0-59) and hours (0-23) as a carry cascade.
- Inputs are one-cycle, already-debounced button pulses.

---
 rtl/stopwatch_dp.sv | 115 +++++++++++
 tb/tb_stopwatch_dp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_dp.sv
// rtl/stopwatch_dp.sv - stopwatch timekeeping datapath with run/stop/clear control
// Prescaler derives the count tick; msec/sec/min/hour form a single-edge carry cascade.
module stopwatch_dp #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       running,
  output logic       tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_STOP  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_presc;
  logic [6:0]      r_msec;
  logic [5:0]      r_sec;
  logic [5:0]      r_min;
  logic [4:0]      r_hour;
  logic            r_running;
  logic            r_tick;
  logic            w_adv;

  // Clear wins over run/stop when both arrive while stopped.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_STOP: begin
        if (btn_clear)
          w_state_next = S_CLEAR;
        else if (btn_run_stop)
          w_state_next = S_RUN;
      end
      S_RUN: begin
        if (btn_run_stop)
          w_state_next = S_STOP;
      end
      S_CLEAR: w_state_next = S_STOP;
      default: w_state_next = S_STOP;
    endcase
  end

  assign w_adv = (r_state == S_RUN) && (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_STOP;
      r_presc   <= '0;
      r_msec    <= '0;
      r_sec     <= '0;
      r_min     <= '0;
      r_hour    <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == S_RUN);
      r_tick    <= w_adv;
      if (r_state == S_CLEAR) begin
        r_presc <= '0;
        r_msec  <= '0;
        r_sec   <= '0;
        r_min   <= '0;
        r_hour  <= '0;
      end else if (r_state == S_RUN) begin
        // The stopping edge still counts, so a restart resumes the partial period.
        if (w_adv) begin
          r_presc <= '0;
          if (r_msec == 7'd99) begin
            r_msec <= '0;
            if (r_sec == 6'd59) begin
              r_sec <= '0;
              if (r_min == 6'd59) begin
                r_min  <= '0;
                r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_msec <= r_msec + 7'd1;
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign msec    = r_msec;
  assign sec     = r_sec;
  assign min     = r_min;
  assign hour    = r_hour;
  assign running = r_running;
  assign tick    = r_tick;

endmodule

// File: tb/tb_stopwatch_dp.sv
// tb/tb_stopwatch_dp.sv - scoreboard bench for stopwatch_dp
// Model tracks elapsed centiseconds as one integer; ticks are checked by a separate monitor.
module tb_stopwatch_dp;

  localparam int DIV     = 10;
  localparam int DAY_CS  = 24 * 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_run_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       running;
  logic       tick;

  stopwatch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .msec         (msec),
    .sec          (sec),
    .min          (min),
    .hour         (hour),
    .running      (running),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cs;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference: mode (0 stop, 1 run, 2 clear), run cycles into the current period, elapsed cs.
  int m_mode  = 0;
  int m_phase = 0;
  int m_cs    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int pack_cs(input int cs);
    return ((cs / 360000) << 24) | (((cs / 6000) % 60) << 16) | (((cs / 100) % 60) << 8) | (cs % 100);
  endfunction

  function automatic int dut_time();
    return (int'(hour) << 24) | (int'(min) << 16) | (int'(sec) << 8) | int'(msec);
  endfunction

  task automatic model_edge(input logic rs, input logic clr);
    case (m_mode)
      0: begin
        if (clr) m_mode = 2;
        else if (rs) m_mode = 1;
      end
      1: begin
        m_phase++;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_cs = (m_cs + 1) % DAY_CS;
          q.push_back('{cyc: cyc + 1, cs: m_cs});
        end
        if (rs) m_mode = 0;
      end
      default: begin
        m_phase = 0;
        m_cs = 0;
        m_mode = 0;
      end
    endcase
  endtask

  task automatic cycle(input logic rs, input logic clr);
    btn_run_stop = rs;
    btn_clear = clr;
    model_edge(rs, clr);
    @(posedge clk);
    #1;
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    chk("running", int'(running), int'(m_mode == 1));
    chk("time", dut_time(), pack_cs(m_cs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_time"}, dut_time(), 0);
    chk({name, "_running"}, int'(running), 0);
    chk({name, "_tick"}, int'(tick), 0);
  endtask

  // Monitor: every presented tick must match the oldest expected increment, value and cycle.
  always @(negedge clk) begin
    if (reset && tick) begin
      if (q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("tick_time", dut_time(), pack_cs(e.cs));
      end
    end
  end

  initial begin
    #1;
    chk_zero("reset_t0");
    for (int i = 0; i < 6; i++) begin
      btn_run_stop = 1'($urandom_range(0, 1));
      btn_clear = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end
    btn_run_stop = 1'b0;
    btn_clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(50);

    cycle(1'b1, 1'b0);
    idle(100 * DIV);

    for (int i = 0; i < 20 && m_phase != 3; i++) cycle(1'b0, 1'b0);
    chk("phase_before_stop", m_phase, 3);
    cycle(1'b1, 1'b0);
    idle(30);
    cycle(1'b1, 1'b0);
    idle(15);

    cycle(1'b0, 1'b1);
    idle(15);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    idle(2);
    cycle(1'b1, 1'b0);
    idle(23);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    idle(3);

    force dut.r_hour = 5'd23;
    force dut.r_min  = 6'd59;
    force dut.r_sec  = 6'd59;
    force dut.r_msec = 7'd98;
    #1;
    release dut.r_hour;
    release dut.r_min;
    release dut.r_sec;
    release dut.r_msec;
    m_cs = DAY_CS - 2;
    chk("preload", dut_time(), pack_cs(m_cs));
    cycle(1'b1, 1'b0);
    idle(3 * DIV);

    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 4));

    if (m_mode != 1) cycle(1'b1, 1'b0);
    idle(23);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    m_mode = 0;
    m_phase = 0;
    m_cs = 0;
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0);
    idle(2 * DIV + 3);

    @(negedge clk);
    #1;
    chk("pending_ticks", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
